// File: rtl/conv_pkg.sv
// Shared constants, state encoding and taps-clamp helper for the convolution accumulator.
package conv_pkg;

   localparam int PRODUCT_W        = 16;
   localparam int TAPS_W           = 5;
   localparam int ACC_W_DEFAULT    = 20;
   localparam int TAPS_MAX_DEFAULT = 25;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } conv_state_t;

   // Window length 0 means a single tap; anything above the kernel limit is clamped.
   function automatic logic [TAPS_W-1:0] clamp_taps(input logic [TAPS_W-1:0] t,
                                                    input logic [TAPS_W-1:0] tmax);
      if (t == '0)
         return TAPS_W'(1);
      else if (t > tmax)
         return tmax;
      else
         return t;
   endfunction

endpackage

// File: rtl/conv_acc_adder.sv
// Accumulate step: acc + zero-extended product with carry-out.
// Optional feature macro: CONV_ACC_SATURATE_EN clamps the result to all-ones on carry.
module conv_acc_adder
   import conv_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEFAULT
) (
   input  logic [ACC_W-1:0]     acc,
   input  logic [PRODUCT_W-1:0] product,
   output logic [ACC_W-1:0]     acc_next,
   output logic                 carry
);

   logic [ACC_W:0] raw;

   assign raw   = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, product};
   assign carry = raw[ACC_W];

`ifdef CONV_ACC_SATURATE_EN
   // Once clamped, any further non-zero product carries again, so the value stays pinned.
   assign acc_next = raw[ACC_W] ? '1 : raw[ACC_W-1:0];
`else
   assign acc_next = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/convolution_accumulator.sv
// Window accumulator: sums TAPS product beats, then holds the sum until consumed.
// Optional feature macro: CONV_ACC_SATURATE_EN (saturating accumulation in conv_acc_adder).
module convolution_accumulator
   import conv_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEFAULT,
   parameter int TAPS_MAX = TAPS_MAX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TAPS_W-1:0]    taps,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PRODUCT_W-1:0] product,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     sum,
   output logic                 ovf
);

   conv_state_t       state;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic              carry;
   logic [TAPS_W-1:0] cnt;
   logic [TAPS_W-1:0] cnt_inc;
   logic [TAPS_W-1:0] taps_lat;
   logic [TAPS_W-1:0] taps_eff;
   logic              ovf_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              xfer;

   assign xfer     = in_valid & in_ready_r;
   assign cnt_inc  = cnt + TAPS_W'(1);
   assign taps_eff = clamp_taps(taps, TAPS_W'(TAPS_MAX));

   conv_acc_adder #(
      .ACC_W (ACC_W)
   ) u_adder (
      .acc      (acc),
      .product  (product),
      .acc_next (acc_next),
      .carry    (carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         taps_lat    <= '0;
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  acc      <= {{(ACC_W - PRODUCT_W){1'b0}}, product};
                  cnt      <= TAPS_W'(1);
                  taps_lat <= taps_eff;
                  ovf_r    <= 1'b0;
                  if (taps_eff == TAPS_W'(1)) begin
                     state       <= HOLD;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (xfer) begin
                  acc   <= acc_next;
                  cnt   <= cnt_inc;
                  ovf_r <= ovf_r | carry;
                  if (cnt_inc == taps_lat) begin
                     state       <= HOLD;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state       <= IDLE;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = acc;
   assign ovf       = ovf_r;

endmodule

// File: tb/tb_convolution_accumulator.sv
// Self-checking bench for convolution_accumulator against an arithmetic window model.
module tb_convolution_accumulator;

   localparam int ACC_W    = 20;
   localparam int TAPS_MAX = 25;

   logic              clk;
   logic              rst;
   logic [4:0]        taps;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       product;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  sum;
   logic              ovf;

   int total_cnt;
   int bad_cnt;
   logic [15:0] pq[$];

   convolution_accumulator #(
      .ACC_W    (ACC_W),
      .TAPS_MAX (TAPS_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .taps      (taps),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp)
      else begin
         bad_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one window from pq and checks it against the arithmetic model.
   task automatic run_window(input int raw_taps, input int later_taps,
                             input bit gaps, input int hold_wait);
      int              eff;
      longint unsigned tot;
      logic [63:0]     exp_sum;
      bit              exp_ovf;
      logic [31:0]     rt;
      logic [31:0]     lt;
      rt  = raw_taps;
      lt  = later_taps;
      eff = (raw_taps == 0) ? 1 : ((raw_taps > TAPS_MAX) ? TAPS_MAX : raw_taps);
      tot = 0;
      for (int i = 0; i < eff; i++) tot += pq[i];
      exp_ovf = (tot >= (64'd1 << ACC_W));
`ifdef CONV_ACC_SATURATE_EN
      exp_sum = exp_ovf ? ((64'd1 << ACC_W) - 1) : tot;
`else
      exp_sum = tot % (64'd1 << ACC_W);
`endif
      out_ready = 1'b0;
      for (int i = 0; i < eff; i++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            product  = 16'($urandom);
            step();
            chk("gap_out_valid", out_valid, 0);
            chk("gap_in_ready", in_ready, 1);
         end
         chk("beat_in_ready", in_ready, 1);
         in_valid = 1'b1;
         product  = pq[i];
         taps     = (i == 0) ? rt[4:0] : lt[4:0];
         step();
         if (i < eff - 1) begin
            chk("mid_out_valid", out_valid, 0);
         end else begin
            chk("last_out_valid", out_valid, 1);
            chk("last_in_ready", in_ready, 0);
            chk("sum", sum, exp_sum);
            chk("ovf", ovf, exp_ovf);
         end
      end
      // Offer a bogus beat during HOLD; it must not be consumed.
      in_valid = gaps;
      product  = 16'hDEAD;
      for (int k = 0; k < hold_wait; k++) begin
         step();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_sum", sum, exp_sum);
         chk("hold_ovf", ovf, exp_ovf);
      end
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("release_out_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      rst       = 1'b1;
      taps      = '0;
      in_valid  = 1'b0;
      product   = '0;
      out_ready = 1'b0;
      step();
      step();
      chk("rst_sum", sum, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      step();

      // 9 taps of 1..9 -> 45, released immediately, next window right behind it
      pq.delete();
      for (int i = 1; i <= 9; i++) pq.push_back(16'(i));
      out_ready = 1'b1;
      run_window(9, 9, 1'b0, 0);

      // single-tap windows: taps=1 and taps=0
      pq.delete();
      pq.push_back(16'hFFFF);
      run_window(1, 1, 1'b0, 0);
      run_window(0, 0, 1'b0, 1);

      // overflow: 25 x 0xFE01
      pq.delete();
      for (int i = 0; i < 25; i++) pq.push_back(16'hFE01);
      run_window(25, 25, 1'b0, 1);

      // taps=4 with toggling valid and a 5-cycle stalled consumer
      pq.delete();
      for (int i = 0; i < 4; i++) pq.push_back(16'($urandom_range(1, 65535)));
      run_window(4, 4, 1'b1, 5);

      // taps changed 9->4 after the first beat
      pq.delete();
      for (int i = 0; i < 9; i++) pq.push_back(16'($urandom));
      run_window(9, 4, 1'b0, 1);

      // taps above the limit are clamped
      pq.delete();
      for (int i = 0; i < 25; i++) pq.push_back(16'($urandom_range(0, 4000)));
      run_window(31, 2, 1'b1, 2);

      // reset in the middle of a window discards it
      taps     = 5'd9;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         product = 16'(100 + i);
         step();
         chk("pre_rst_out_valid", out_valid, 0);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_ovf", ovf, 0);
      step();
      chk("post_rst_out_valid", out_valid, 0);
      pq.delete();
      for (int i = 0; i < 9; i++) pq.push_back(16'd2);
      run_window(9, 9, 1'b0, 0);

      // random windows
      for (int w = 0; w < 8; w++) begin
         pq.delete();
         for (int i = 0; i < 25; i++) pq.push_back(16'($urandom));
         run_window(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    1'b1, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/convolution_accumulator.md
CONVOLUTION_ACCUMULATOR -- requirements
Module: convolution_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 20: accumulator/sum width in bits, legal range 17..32.
REQ-002 SHALL have parameter TAPS_MAX, default 25: largest kernel window, 3x3 through 5x5 supported.
REQ-003 SHALL have clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have taps, input, 5: window length; sampled only on the first accepted beat of a window.
REQ-006 SHALL have in_valid, input, 1: product beat is valid.
REQ-007 SHALL have in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have product, input, 16: unsigned 8x8 multiplier product from the upstream stage.
REQ-009 SHALL have out_valid, output, 1: sum is valid.
REQ-010 SHALL have out_ready, input, 1: consumer accepts the sum.
REQ-011 SHALL have sum, output, ACC_W: accumulated window result.
REQ-012 SHALL have ovf, output, 1: accumulation carried past ACC_W bits during this window.

Function
REQ-013 SHALL transfer a beat only on a clk edge where in_valid and in_ready are both 1.
REQ-014 SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in HOLD, and out_valid=1 only in HOLD.
REQ-016 IDLE: on transfer, SHALL set acc=zero-extended product, cnt=1, latch taps (0 treated as 1, >TAPS_MAX clamped to TAPS_MAX), clear ovf; then go to HOLD if latched taps==1, else ACCUM.
REQ-017 ACCUM: on transfer, SHALL set acc=acc+product and cnt=cnt+1; go to HOLD when the new cnt equals latched taps.
REQ-018 ACCUM without transfer: SHALL hold acc, cnt and state; a window has no timeout.
REQ-019 HOLD: SHALL hold sum/ovf stable while out_ready=0, and go to IDLE on the edge where out_ready=1.
REQ-020 Latency: out_valid SHALL rise on the clk edge that accepts the final beat of the window; the sum is visible in the following cycle.
REQ-021 Throughput: one window of N taps SHALL occupy N+1 cycles minimum; the IDLE cycle after HOLD accepts the next window's first beat.
REQ-022 SHALL set ovf when any addition carries out of bit ACC_W-1, and keep it sticky until the next window starts.
REQ-023 A change on taps mid-window SHALL be ignored.
REQ-024 in_valid asserted during HOLD SHALL not be consumed; the upstream must hold the beat.

Reset
REQ-025 On rst=1 at a clk edge, SHALL go to IDLE with acc=0, cnt=0, sum=0, ovf=0, out_valid=0 and in_ready=1 in the next cycle.
REQ-026 rst SHALL override any in-flight window or pending HOLD, discarding it with no output.

Configuration
REQ-027 With CONV_ACC_SATURATE_EN defined, an overflowing addition SHALL clamp acc to 2^ACC_W-1 and hold it there for the rest of the window (ovf=1).
REQ-028 Without CONV_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W; ovf still reports the carry.

Structure
REQ-029 Shared package conv_pkg SHALL hold PRODUCT_W=16, TAPS_W=5, the default ACC_W/TAPS_MAX, and the state enumeration IDLE/ACCUM/HOLD.
REQ-030 The add/saturate datapath SHALL be one sub-module, conv_acc_adder (inputs acc, product; outputs next acc, carry); the FSM and counter stay in the top module.

Verification
REQ-031 taps=9, products 1..9 back-to-back, out_ready=1 -> sum=45, ovf=0, out_valid exactly 1 cycle, next window accepted in the following cycle.
REQ-032 taps=1, product=0xFFFF -> sum=65535 on the next cycle; taps=0 behaves identically.
REQ-033 taps=25, 25 x 0xFE01 at ACC_W=20 -> ovf=1; sum=0xFFFFF with CONV_ACC_SATURATE_EN, sum=1625625 mod 2^20=577049 without it.
REQ-034 taps=4, in_valid toggled 1/0 and out_ready held 0 for 5 cycles -> sum stable in HOLD, in_ready=0, and no beat lost or duplicated.
REQ-035 rst pulsed after 3 of 9 beats -> no out_valid; the next 9-beat window of 2s gives sum=18.
REQ-036 taps changed 9->4 after the first beat -> window still closes after 9 beats.
